// File: rtl/clk_div_multi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_div_pkg                                              |
// | Description : Shared constants and helpers for the multi-channel       |
// |               clock divider (counter width, reset divisor, system      |
// |               clock rate, divisor-from-frequency helper).              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package clk_div_pkg;

    localparam int                       CNT_W_DEFAULT = 26;
    localparam logic [CNT_W_DEFAULT-1:0] DEFAULT_DIV   = 26'd20000000;
    localparam int unsigned              SYS_CLK_HZ    = 100_000_000;

    // Half-period divisor producing an output of f Hz from the system clock.
    function automatic logic [CNT_W_DEFAULT-1:0] div_for_hz(input int unsigned f);
        int unsigned v;
        v = SYS_CLK_HZ / (2 * f) - 1;
        return v[CNT_W_DEFAULT-1:0];
    endfunction

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_div_multi_if                                         |
// | Description : Enable/configuration inputs and divided-clock outputs    |
// |               of clk_div_multi, bundled with master/slave views.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEFAULT
);

    localparam int CH_W = ch_width(N_CH);

    logic [N_CH-1:0]  en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  clk_o;
    logic [N_CH-1:0]  tick_o;
    logic [N_CH-1:0]  pend_o;

    modport master (
        output en, cfg_we, cfg_ch, cfg_div,
        input  clk_o, tick_o, pend_o
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_div,
        output clk_o, tick_o, pend_o
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_multi_chan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_div_chan                                             |
// | Description : One divider channel: half-period counter, active and     |
// |               pending divisor, registered square wave and rising tick. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_div_pkg::DEFAULT_DIV)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_we,
    input  wire logic [CNT_W-1:0] i_div,
    input  wire logic             i_sync,
    output logic                  o_clk,
    output logic                  o_tick,
    output logic                  o_pend
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    // Count half-periods; a pending divisor only takes effect at count 0 or while idle,
    // so the counter can never pass div_act. A write in the same cycle re-arms pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_div_act  <= DEFAULT_DIV;
            r_div_pend <= DEFAULT_DIV;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (i_sync) begin
                r_count <= '0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else if (!i_en) begin
                r_count <= '0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                if (r_pend) begin
                    r_div_act <= r_div_pend;
                    r_pend    <= 1'b0;
                end
            end else if (r_count == r_div_act) begin
                r_count <= '0;
                r_clk   <= ~r_clk;
                r_tick  <= ~r_clk;
                if (r_pend) begin
                    r_div_act <= r_div_pend;
                    r_pend    <= 1'b0;
                end
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_tick  <= 1'b0;
            end
            if (i_we) begin
                r_div_pend <= i_div;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_div_multi                                            |
// | Description : N_CH independent programmable clock dividers with        |
// |               glitch-free divisor updates. Optional macro              |
// |               CLK_DIV_MULTI_SYNC_EN adds a sync_start input that       |
// |               restarts every channel in phase.                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_div_pkg::DEFAULT_DIV)
) (
    input  wire logic      clk,
    input  wire logic      rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
    input  wire logic      sync_start,
`endif
    clk_div_multi_if.slave bus
);

    localparam int CH_W = ch_width(N_CH);

    logic            w_sync;
    logic [N_CH-1:0] w_we;
    logic [N_CH-1:0] w_clk;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_pend;

`ifdef CLK_DIV_MULTI_SYNC_EN
    assign w_sync = sync_start;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_we[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_en   (bus.en[i]),
            .i_we   (w_we[i]),
            .i_div  (bus.cfg_div),
            .i_sync (w_sync),
            .o_clk  (w_clk[i]),
            .o_tick (w_tick[i]),
            .o_pend (w_pend[i])
        );
    end

    assign bus.clk_o  = w_clk;
    assign bus.tick_o = w_tick;
    assign bus.pend_o = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_clk_div_multi                                         |
// | Description : Directed self-checking bench for clk_div_multi (4- and   |
// |               3-channel instances, divisor 3 at reset). The sync test  |
// |               is built when CLK_DIV_MULTI_SYNC_EN is defined.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_clk_div_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CLK_DIV_MULTI_SYNC_EN
    logic sync0 = 1'b0;
    logic sync1 = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_div_multi_if #(.N_CH(4), .CNT_W(8)) bus0 ();
    clk_div_multi_if #(.N_CH(3), .CNT_W(8)) bus1 ();

    clk_div_multi #(.N_CH(4), .CNT_W(8), .DEFAULT_DIV(8'd3)) dut0 (
        .clk        (clk),
        .rst        (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
        .sync_start (sync0),
`endif
        .bus        (bus0)
    );

    clk_div_multi #(.N_CH(3), .CNT_W(8), .DEFAULT_DIV(8'd3)) dut1 (
        .clk        (clk),
        .rst        (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
        .sync_start (sync1),
`endif
        .bus        (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;   // enabled edges since the run started

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Divisor 3 from the first enabled edge: toggle every 4 edges, first rise at edge 4.
    function automatic logic base_clk(input int m);
        return ((m / 4) % 2) == 1;
    endfunction

    function automatic logic base_tick(input int m);
        return (m % 8) == 4;
    endfunction

    // Hand-derived schedule of dut0 for the directed writes/enables below: {clk, tick}.
    function automatic logic [1:0] exp_ct(input int ch, input int m);
        int p;
        case (ch)
            0: begin
                if (m < 62) return {base_clk(m), base_tick(m)};
                if (m < 64) return 2'b00;
                p = m - 63;
                return {((p / 2) % 2) == 1, (p % 4) == 2};
            end
            1: begin
                if (m < 24) return {base_clk(m), base_tick(m)};
                p = m - 24;
                return {((p / 2) % 2) == 1, (p % 4) == 2};
            end
            2: begin
                if (m < 48) return {base_clk(m), base_tick(m)};
                p = m - 48;
                return {(p % 2) == 1, (p % 2) == 1};
            end
            default: return {base_clk(m), base_tick(m)};
        endcase
    endfunction

    function automatic logic [3:0] exp_pend(input int m);
        if (m == 22 || m == 23) return 4'b0010;
        if (m >= 44 && m <= 47) return 4'b0100;
        if (m == 62)            return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic test_reset();
        bus0.en = '0; bus0.cfg_we = 1'b0; bus0.cfg_ch = '0; bus0.cfg_div = '0;
        bus1.en = '0; bus1.cfg_we = 1'b0; bus1.cfg_ch = '0; bus1.cfg_div = '0;
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus0.clk_o !== 4'b0 || bus0.tick_o !== 4'b0 || bus0.pend_o !== 4'b0) begin
            n_err++;
            $display("FAIL reset_dut0 got clk=%b tick=%b pend=%b exp 0000", bus0.clk_o, bus0.tick_o, bus0.pend_o);
        end
        n_cmp++;
        if (bus1.clk_o !== 3'b0 || bus1.tick_o !== 3'b0 || bus1.pend_o !== 3'b0) begin
            n_err++;
            $display("FAIL reset_dut1 got clk=%b tick=%b pend=%b exp 000", bus1.clk_o, bus1.tick_o, bus1.pend_o);
        end
        rst = 1'b0;
        bus0.en = 4'hF;
        bus1.en = 3'h7;
        n = 0;
    endtask

    // Runs dut0 up to edge 'last', comparing every cycle against the schedule.
    task automatic run_dut0(input int last, input string name);
        logic [3:0] ec, et;
        logic [1:0] ct;
        while (n < last) begin
            step();
            for (int c = 0; c < 4; c++) begin
                ct = exp_ct(c, n);
                ec[c] = ct[1];
                et[c] = ct[0];
            end
            n_cmp++;
            if (bus0.clk_o !== ec || bus0.tick_o !== et || bus0.pend_o !== exp_pend(n)) begin
                n_err++;
                $display("FAIL %s edge=%0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=%b",
                         name, n, bus0.clk_o, bus0.tick_o, bus0.pend_o, ec, et, exp_pend(n));
            end
        end
    endtask

    task automatic test_free_run();
        run_dut0(21, "free_run");
    endtask

    // Two writes to ch1 mid half-period: last one (div 1) wins at the next terminal.
    task automatic test_write_mid();
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 2'd1; bus0.cfg_div = 8'd5;
        run_dut0(22, "write_mid");
        bus0.cfg_div = 8'd1;
        run_dut0(23, "write_mid");
        bus0.cfg_we = 1'b0;
        run_dut0(40, "write_mid");
    endtask

    // Write ch2 div 0 on the edge of its terminal count: old divisor stays one more half-period.
    task automatic test_write_terminal();
        run_dut0(43, "write_term");
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 2'd2; bus0.cfg_div = 8'd0;
        run_dut0(44, "write_term");
        bus0.cfg_we = 1'b0;
        run_dut0(58, "write_term");
    endtask

    // Drop en[0] in its high phase with a write; divisor applies while idle, then re-enable.
    task automatic test_disable();
        run_dut0(61, "disable");
        bus0.en[0] = 1'b0;
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 2'd0; bus0.cfg_div = 8'd1;
        run_dut0(62, "disable");
        bus0.cfg_we = 1'b0;
        run_dut0(63, "disable");
        bus0.en[0] = 1'b1;
        run_dut0(76, "disable");
    endtask

    // cfg_ch=3 on the 3-channel instance must be ignored.
    task automatic test_bad_channel();
        bus1.cfg_we = 1'b1; bus1.cfg_ch = 2'd3; bus1.cfg_div = 8'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (bus1.pend_o !== 3'b000 || bus1.clk_o !== {3{base_clk(n)}} || bus1.tick_o !== {3{base_tick(n)}}) begin
                n_err++;
                $display("FAIL bad_channel edge=%0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=000",
                         n, bus1.clk_o, bus1.tick_o, bus1.pend_o, {3{base_clk(n)}}, {3{base_tick(n)}});
            end
        end
        bus1.cfg_we = 1'b0;
    endtask

    // Reset mid-count with a pending write and cfg_we/en active: all cleared, divisor back to 3.
    task automatic test_reset_mid();
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 2'd3; bus0.cfg_div = 8'd0;
        step();
        n_cmp++;
        if (bus0.pend_o !== 4'b1000 || bus0.clk_o !== 4'b0101) begin
            n_err++;
            $display("FAIL pre_reset got clk=%b pend=%b exp clk=0101 pend=1000", bus0.clk_o, bus0.pend_o);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (bus0.clk_o !== 4'b0 || bus0.tick_o !== 4'b0 || bus0.pend_o !== 4'b0) begin
            n_err++;
            $display("FAIL reset_mid got clk=%b tick=%b pend=%b exp 0000", bus0.clk_o, bus0.tick_o, bus0.pend_o);
        end
        rst = 1'b0;
        bus0.cfg_we = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (bus0.clk_o !== {4{base_clk(k)}} || bus0.tick_o !== {4{base_tick(k)}} || bus0.pend_o !== 4'b0) begin
                n_err++;
                $display("FAIL after_reset k=%0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=0000",
                         k, bus0.clk_o, bus0.tick_o, bus0.pend_o, {4{base_clk(k)}}, {4{base_tick(k)}});
            end
        end
    endtask

`ifdef CLK_DIV_MULTI_SYNC_EN
    // ch0 and ch3 at divisor 2 started one edge apart, then realigned by sync_start.
    task automatic test_sync();
        logic e;
        bus0.en = 4'b0000;
        step();
        bus0.cfg_we = 1'b1; bus0.cfg_ch = 2'd0; bus0.cfg_div = 8'd2;
        step();
        bus0.cfg_ch = 2'd3;
        step();
        bus0.cfg_we = 1'b0;
        step();
        n_cmp++;
        if (bus0.pend_o !== 4'b0) begin
            n_err++;
            $display("FAIL sync_pend got pend=%b exp 0000", bus0.pend_o);
        end
        bus0.en = 4'b0001;
        step();
        bus0.en = 4'b1001;
        repeat (4) step();
        sync0 = 1'b1;
        step();
        sync0 = 1'b0;
        n_cmp++;
        if (bus0.clk_o !== 4'b0 || bus0.tick_o !== 4'b0) begin
            n_err++;
            $display("FAIL sync_clear got clk=%b tick=%b exp 0000", bus0.clk_o, bus0.tick_o);
        end
        for (int k = 1; k <= 18; k++) begin
            step();
            e = ((k / 3) % 2) == 1;
            n_cmp++;
            if (bus0.clk_o !== {e, 2'b00, e} || bus0.tick_o !== {(k % 6) == 3, 2'b00, (k % 6) == 3}) begin
                n_err++;
                $display("FAIL sync_align k=%0d got clk=%b tick=%b exp clk=%b", k, bus0.clk_o, bus0.tick_o, {e, 2'b00, e});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_write_mid();
        test_write_terminal();
        test_disable();
        test_bad_channel();
        test_reset_mid();
`ifdef CLK_DIV_MULTI_SYNC_EN
        test_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
